mips_multicycle_control: RTL and testbench
==========================================

# mips_multicycle_control

Control unit for the multicycle MIPS datapath. A Moore-style main state machine sequences fetch, decode, execute, memory and writeback. An embedded ALU decoder produces the 3-bit `aluOp` consumed by the datapath ALU. The block sits between the instruction register (opcode/funct), the ALU zero flag, the memory ready signal, and every datapath mux and enable.

## Interface
Parameters:
- none

Ports:
- `clk`  in  1  — single clock; all state updates on the rising edge.
- `reset`  in  1  — synchronous, active-high.
- `opcode`  in  6  — instr[31:26] from the instruction register.
- `funct`  in  6  — instr[5:0] from the instruction register.
- `zero`  in  1  — ALU zero flag.
- `memReady`  in  1  — memory has completed the current access.
- `pcWrite`  out  1  — PC register enable.
- `IorD`  out  1  — memory address select: 0 = PC, 1 = ALUOut.
- `memWrite`  out  1  — memory write strobe.
- `irWrite`  out  1  — instruction register enable.
- `regDst`  out  1  — register-file write select: 0 = rt, 1 = rd.
- `memToReg`  out  1  — writeback select: 0 = ALUOut, 1 = data register.
- `regWrite`  out  1  — register-file write enable.
- `aluSrcA`  out  1  — ALU A select: 0 = PC, 1 = regA.
- `aluSrcB`  out  2  — ALU B select: 00 = regB, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left 2.
- `pcSrc`  out  2  — PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `aluOp`  out  3  — ALU operation code:
  - 000 AND
  - 001 OR
  - 010 ADD
  - 110 SUB
  - 111 SLT
- `illegal`  out  1  — one-cycle pulse on an unsupported opcode or funct.
- `state`  out  4  — current state, for debug.

## Operation
State encodings:
- FETCH = 0
- DECODE = 1
- MEMADR = 2
- MEMRD = 3
- MEMWB = 4
- MEMWR = 5
- EXECUTE = 6
- ALUWB = 7
- BRANCH = 8
- ADDIEXEC = 9
- ADDIWB = 10
- JUMP = 11
- Encodings 12–15 are unreachable and transition to FETCH.

Output rules:
- Default for every output is 0.
- `aluOp` defaults to 010 (ADD) in every state that does not specify it.

Supported opcodes:
- lw = 100011
- sw = 101011
- R-type = 000000
- beq = 000100
- addi = 001000
- j = 000010

R-type funct to `aluOp` decode:
- 100000 → 010
- 100010 → 110
- 100100 → 000
- 100101 → 001
- 101010 → 111

Per-state outputs and transitions:
- **FETCH:** `IorD`=0, `aluSrcA`=0, `aluSrcB`=01, `aluOp`=010, `pcSrc`=00. `irWrite` = `pcWrite` = `memReady`. If `memReady`=1, go to DECODE; otherwise stay in FETCH.
- **DECODE:** `aluSrcA`=0, `aluSrcB`=11, `aluOp`=010 (precomputes the branch target).
  - lw/sw → MEMADR
  - R-type with supported funct → EXECUTE
  - beq → BRANCH
  - addi → ADDIEXEC
  - j → JUMP
  - any other opcode, or R-type with unsupported funct → pulse `illegal`=1 and go to FETCH. No write of any kind occurs.
- **MEMADR:** `aluSrcA`=1, `aluSrcB`=10, `aluOp`=010. lw → MEMRD; sw → MEMWR.
- **MEMRD:** `IorD`=1. Stay until `memReady`=1, then go to MEMWB.
- **MEMWB:** `regDst`=0, `memToReg`=1, `regWrite`=1. Go to FETCH.
- **MEMWR:** `IorD`=1, `memWrite`=1. `memWrite` is held high until the cycle where `memReady`=1, then go to FETCH.
- **EXECUTE:** `aluSrcA`=1, `aluSrcB`=00, `aluOp`=decode(`funct`). Go to ALUWB.
- **ALUWB:** `regDst`=1, `memToReg`=0, `regWrite`=1. `aluOp` remains decode(`funct`). Go to FETCH.
- **BRANCH:** `aluSrcA`=1, `aluSrcB`=00, `aluOp`=110, `pcSrc`=01, `pcWrite`=`zero`. Go to FETCH.
- **ADDIEXEC:** `aluSrcA`=1, `aluSrcB`=10, `aluOp`=010. Go to ADDIWB.
- **ADDIWB:** `regDst`=0, `memToReg`=0, `regWrite`=1. Go to FETCH.
- **JUMP:** `pcSrc`=10, `pcWrite`=1. Go to FETCH.

## Timing
- All outputs are combinational from `state`, plus:
  - `zero` in BRANCH
  - `memReady` in FETCH, MEMRD and MEMWR
  - `opcode`/`funct` in DECODE, EXECUTE and ALUWB
- The state register updates on the rising edge of `clk`.
- **Reset:** while `reset`=1, every output except `aluOp` and `state` is forced to 0. `aluOp` is forced to 010. The next state is FETCH, so `state`=0 on the edge after reset is sampled high.
- Reset asserted mid-instruction aborts it. No `regWrite` or `memWrite` is issued in the reset cycle or after it.
- **Latency with `memReady` tied to 1:**
  - lw: 5 cycles
  - sw: 4 cycles
  - R-type: 4 cycles
  - addi: 4 cycles
  - beq: 3 cycles
  - j: 3 cycles
  - illegal: 2 cycles
- Each cycle of `memReady`=0 adds one wait cycle in FETCH, MEMRD or MEMWR.
- While waiting, outputs are held stable. `irWrite`, `pcWrite` and the state transition occur only in the cycle where `memReady`=1.
- `illegal` is high for exactly one cycle (the DECODE cycle).
- `opcode` and `funct` must be stable from DECODE through the end of the instruction. The IR is written only in FETCH, which guarantees this.

## Test plan
1. **Reset, then fetch:** assert `reset` with `memReady`=1, then release. Expect `state`=0, `irWrite`=1, `pcWrite`=1, `aluSrcB`=01, `aluOp`=010; next `state`=1.
2. **R-type sequence:** `opcode`=000000, `funct`=101010, `memReady`=1. Expect states 0→1→6→7→0. In EXECUTE and ALUWB, `aluOp`=111. In ALUWB, `regWrite`=1 and `regDst`=1. Repeat for `funct` 100010 (expect 110), 100100 (000) and 100101 (001).
3. **lw with wait states:** `opcode`=100011, `memReady` low for 2 cycles in MEMRD. Expect 0→1→2→3→3→3→4→0. In MEMWB, `memToReg`=1 and `regWrite`=1. No `regWrite` occurs before MEMWB.
4. **beq:** `opcode`=000100. With `zero`=1 in BRANCH, expect `pcWrite`=1, `pcSrc`=01, `aluOp`=110. Repeat with `zero`=0 and expect `pcWrite`=0. Both runs return to FETCH.
5. **sw and j:**
   - sw (`opcode`=101011): expect 0→1→2→5→0, with `memWrite`=1 and `IorD`=1 only in state 5.
   - j (`opcode`=000010): expect 0→1→11→0, with `pcWrite`=1 and `pcSrc`=10 in state 11.
6. **Illegal instruction and mid-instruction reset:**
   - `opcode`=111111: `illegal`=1 for one cycle in DECODE, then FETCH, with no writes.
   - R-type `funct`=000000: same behaviour as above.
   - `reset` asserted in ADDIEXEC: no `regWrite` occurs, and `state`=0 on the next edge.

Source files
------------

// File: rtl/mips_multicycle_control_if.sv
// Control bundle between the multicycle MIPS controller and its datapath.
// master = controller side, slave = datapath (or bench) side.
interface mips_multicycle_control_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       memReady;
  logic       pcWrite;
  logic       IorD;
  logic       memWrite;
  logic       irWrite;
  logic       regDst;
  logic       memToReg;
  logic       regWrite;
  logic       aluSrcA;
  logic [1:0] aluSrcB;
  logic [1:0] pcSrc;
  logic [2:0] aluOp;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  opcode, funct, zero, memReady,
    output pcWrite, IorD, memWrite, irWrite, regDst, memToReg, regWrite,
           aluSrcA, aluSrcB, pcSrc, aluOp, illegal, state
  );

  modport slave (
    output opcode, funct, zero, memReady,
    input  pcWrite, IorD, memWrite, irWrite, regDst, memToReg, regWrite,
           aluSrcA, aluSrcB, pcSrc, aluOp, illegal, state
  );
endinterface

// File: rtl/mips_multicycle_control.sv
// Moore FSM sequencing the multicycle MIPS datapath, with embedded ALU decoder.
// 2-5 cycles per instruction; memReady=0 stalls in FETCH/MEMRD/MEMWR with outputs held.
module mips_multicycle_control (
  input  logic                              clk,
  input  logic                              reset,
  mips_multicycle_control_if.master         bus
);
  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMRD    = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWR    = 4'd5;
  localparam logic [3:0] S_EXECUTE  = 4'd6;
  localparam logic [3:0] S_ALUWB    = 4'd7;
  localparam logic [3:0] S_BRANCH   = 4'd8;
  localparam logic [3:0] S_ADDIEXEC = 4'd9;
  localparam logic [3:0] S_ADDIWB   = 4'd10;
  localparam logic [3:0] S_JUMP     = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  logic [3:0] r_state;
  logic [3:0] w_next;
  logic       w_funct_ok;
  logic [2:0] w_funct_aluop;
  logic       w_instr_ok;

  always_comb begin
    w_funct_ok    = 1'b1;
    w_funct_aluop = ALU_ADD;
    case (bus.funct)
      6'b100000: w_funct_aluop = ALU_ADD;
      6'b100010: w_funct_aluop = ALU_SUB;
      6'b100100: w_funct_aluop = ALU_AND;
      6'b100101: w_funct_aluop = ALU_OR;
      6'b101010: w_funct_aluop = ALU_SLT;
      default:   w_funct_ok    = 1'b0;
    endcase
  end

  always_comb begin
    w_instr_ok = 1'b0;
    case (bus.opcode)
      OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: w_instr_ok = 1'b1;
      OP_RTYPE:                            w_instr_ok = w_funct_ok;
      default:                             w_instr_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:    w_next = bus.memReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        // Unsupported instructions fall straight back to FETCH without any write.
        if (!w_instr_ok)                                      w_next = S_FETCH;
        else if (bus.opcode == OP_LW || bus.opcode == OP_SW)  w_next = S_MEMADR;
        else if (bus.opcode == OP_RTYPE)                      w_next = S_EXECUTE;
        else if (bus.opcode == OP_BEQ)                        w_next = S_BRANCH;
        else if (bus.opcode == OP_ADDI)                       w_next = S_ADDIEXEC;
        else                                                  w_next = S_JUMP;
      end
      S_MEMADR:   w_next = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:    w_next = bus.memReady ? S_MEMWB : S_MEMRD;
      S_MEMWR:    w_next = bus.memReady ? S_FETCH : S_MEMWR;
      S_EXECUTE:  w_next = S_ALUWB;
      S_ADDIEXEC: w_next = S_ADDIWB;
      default:    w_next = S_FETCH;
    endcase
  end

  always_comb begin
    bus.pcWrite  = 1'b0;
    bus.IorD     = 1'b0;
    bus.memWrite = 1'b0;
    bus.irWrite  = 1'b0;
    bus.regDst   = 1'b0;
    bus.memToReg = 1'b0;
    bus.regWrite = 1'b0;
    bus.aluSrcA  = 1'b0;
    bus.aluSrcB  = 2'b00;
    bus.pcSrc    = 2'b00;
    bus.aluOp    = ALU_ADD;
    bus.illegal  = 1'b0;
    bus.state    = r_state;
    // Reset masks every strobe so an aborted instruction cannot write anything.
    if (!reset) begin
      case (r_state)
        S_FETCH: begin
          bus.aluSrcB = 2'b01;
          bus.irWrite = bus.memReady;
          bus.pcWrite = bus.memReady;
        end
        S_DECODE: begin
          bus.aluSrcB = 2'b11;
          bus.illegal = !w_instr_ok;
        end
        S_MEMADR: begin
          bus.aluSrcA = 1'b1;
          bus.aluSrcB = 2'b10;
        end
        S_MEMRD:  bus.IorD = 1'b1;
        S_MEMWB: begin
          bus.memToReg = 1'b1;
          bus.regWrite = 1'b1;
        end
        S_MEMWR: begin
          bus.IorD     = 1'b1;
          bus.memWrite = 1'b1;
        end
        S_EXECUTE: begin
          bus.aluSrcA = 1'b1;
          bus.aluOp   = w_funct_aluop;
        end
        S_ALUWB: begin
          bus.regDst   = 1'b1;
          bus.regWrite = 1'b1;
          bus.aluOp    = w_funct_aluop;
        end
        S_BRANCH: begin
          bus.aluSrcA = 1'b1;
          bus.aluOp   = ALU_SUB;
          bus.pcSrc   = 2'b01;
          bus.pcWrite = bus.zero;
        end
        S_ADDIEXEC: begin
          bus.aluSrcA = 1'b1;
          bus.aluSrcB = 2'b10;
        end
        S_ADDIWB: bus.regWrite = 1'b1;
        S_JUMP: begin
          bus.pcSrc   = 2'b10;
          bus.pcWrite = 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mips_multicycle_control.sv
// Bench for mips_multicycle_control: per-instruction expected traces built from state paths.
module tb_mips_multicycle_control;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  typedef struct packed {
    logic [3:0] st;
    logic pcw, iord, mw, irw, rdst, m2r, rw, asa;
    logic [1:0] asb, pcs;
    logic [2:0] aop;
    logic ill;
  } obs_t;

  typedef struct packed {
    logic mr;
    obs_t o;
  } step_t;

  logic clk = 1'b0;
  logic reset;
  int   errs = 0;
  int   checks = 0;

  mips_multicycle_control_if bus();

  mips_multicycle_control dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  function automatic obs_t sample();
    obs_t o;
    o.st = bus.state;     o.pcw = bus.pcWrite;   o.iord = bus.IorD;
    o.mw = bus.memWrite;  o.irw = bus.irWrite;   o.rdst = bus.regDst;
    o.m2r = bus.memToReg; o.rw = bus.regWrite;   o.asa = bus.aluSrcA;
    o.asb = bus.aluSrcB;  o.pcs = bus.pcSrc;     o.aop = bus.aluOp;
    o.ill = bus.illegal;
    return o;
  endfunction

  // {valid, aluOp} for an R-type funct field
  function automatic logic [3:0] fdec(input logic [5:0] f);
    case (f)
      6'b100000: return 4'b1010;
      6'b100010: return 4'b1110;
      6'b100100: return 4'b1000;
      6'b100101: return 4'b1001;
      6'b101010: return 4'b1111;
      default:   return 4'b0010;
    endcase
  endfunction

  // Expected outputs for one cycle spent in state st
  function automatic obs_t mk(input int st, input logic mr, input logic z,
                              input logic [2:0] dop, input logic ill);
    obs_t o;
    o = '0;
    o.st = 4'(st);
    o.aop = 3'b010;
    case (st)
      0:  begin o.asb = 2'b01; o.irw = mr; o.pcw = mr; end
      1:  begin o.asb = 2'b11; o.ill = ill; end
      2:  begin o.asa = 1'b1; o.asb = 2'b10; end
      3:  o.iord = 1'b1;
      4:  begin o.m2r = 1'b1; o.rw = 1'b1; end
      5:  begin o.iord = 1'b1; o.mw = 1'b1; end
      6:  begin o.asa = 1'b1; o.aop = dop; end
      7:  begin o.rdst = 1'b1; o.rw = 1'b1; o.aop = dop; end
      8:  begin o.asa = 1'b1; o.aop = 3'b110; o.pcs = 2'b01; o.pcw = z; end
      9:  begin o.asa = 1'b1; o.asb = 2'b10; end
      10: o.rw = 1'b1;
      11: begin o.pcs = 2'b10; o.pcw = 1'b1; end
      default: ;
    endcase
    return o;
  endfunction

  // Builds the instruction's state path, then turns it into per-cycle expectations.
  task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input int fw, input int mw, output step_t q[$]);
    int   sts[$];
    logic mrs[$];
    logic [3:0] d;
    logic ill;
    d = fdec(fn);
    q = {};
    for (int w = 0; w < fw; w++) begin sts.push_back(0); mrs.push_back(1'b0); end
    sts.push_back(0); mrs.push_back(1'b1);
    sts.push_back(1); mrs.push_back(1'($urandom_range(0, 1)));
    ill = 1'b0;
    case (op)
      OP_LW: begin
        sts.push_back(2); mrs.push_back(1'($urandom_range(0, 1)));
        for (int w = 0; w < mw; w++) begin sts.push_back(3); mrs.push_back(1'b0); end
        sts.push_back(3); mrs.push_back(1'b1);
        sts.push_back(4); mrs.push_back(1'($urandom_range(0, 1)));
      end
      OP_SW: begin
        sts.push_back(2); mrs.push_back(1'($urandom_range(0, 1)));
        for (int w = 0; w < mw; w++) begin sts.push_back(5); mrs.push_back(1'b0); end
        sts.push_back(5); mrs.push_back(1'b1);
      end
      OP_R: begin
        if (d[3]) begin
          sts.push_back(6); mrs.push_back(1'($urandom_range(0, 1)));
          sts.push_back(7); mrs.push_back(1'($urandom_range(0, 1)));
        end else ill = 1'b1;
      end
      OP_BEQ:  begin sts.push_back(8); mrs.push_back(1'($urandom_range(0, 1))); end
      OP_ADDI: begin
        sts.push_back(9);  mrs.push_back(1'($urandom_range(0, 1)));
        sts.push_back(10); mrs.push_back(1'($urandom_range(0, 1)));
      end
      OP_J:    begin sts.push_back(11); mrs.push_back(1'($urandom_range(0, 1))); end
      default: ill = 1'b1;
    endcase
    for (int i = 0; i < sts.size(); i++)
      q.push_back({mrs[i], mk(sts[i], mrs[i], z, d[2:0], ill)});
  endtask

  // Drives one instruction from posedge+1 in FETCH; records outputs mid-cycle.
  task automatic run_trace(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input step_t q[$], output obs_t obs[$], output logic [3:0] end_st);
    obs = {};
    bus.opcode = op;
    bus.funct  = fn;
    bus.zero   = z;
    for (int i = 0; i < q.size(); i++) begin
      bus.memReady = q[i].mr;
      #3;
      obs.push_back(sample());
      @(posedge clk);
      #1;
    end
    end_st = bus.state;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    obs_t o, exp_f;
    reset = 1'b1; bus.memReady = 1'b1; bus.opcode = 6'b111111;
    bus.funct = 6'b0; bus.zero = 1'b1;
    @(posedge clk);
    #4;
    o = sample();
    exp_f = '0; exp_f.aop = 3'b010; exp_f.st = o.st;
    checks++;
    if (o !== exp_f) begin errs++; $display("FAIL reset_forced: got %05h want %05h", o, exp_f); end
    checks++;
    if (o.st !== 4'd0) begin errs++; $display("FAIL reset_state: got %0d want 0", o.st); end
    reset = 1'b0;
    #1;
    o = sample();
    exp_f = '0; exp_f.irw = 1'b1; exp_f.pcw = 1'b1; exp_f.asb = 2'b01; exp_f.aop = 3'b010;
    checks++;
    if (o !== exp_f) begin errs++; $display("FAIL reset_fetch: got %05h want %05h", o, exp_f); end
    @(posedge clk);
    #1;
    checks++;
    if (bus.state !== 4'd1) begin errs++; $display("FAIL reset_to_decode: got %0d want 1", bus.state); end
    do_reset();
  endtask

  task automatic test_rtype();
    logic [5:0] fl [0:4];
    step_t q[$]; obs_t obs[$]; logic [3:0] es; logic z;
    fl = '{6'b101010, 6'b100010, 6'b100100, 6'b100101, 6'b100000};
    foreach (fl[k]) begin
      z = 1'($urandom_range(0, 1));
      build(OP_R, fl[k], z, 0, 0, q);
      run_trace(OP_R, fl[k], z, q, obs, es);
      for (int i = 0; i < q.size(); i++) begin
        checks++;
        if (obs[i] !== q[i].o) begin
          errs++; $display("FAIL rtype f=%b cyc%0d: got %05h want %05h", fl[k], i, obs[i], q[i].o);
        end
      end
      checks++;
      if (es !== 4'd0) begin errs++; $display("FAIL rtype_end f=%b: got %0d want 0", fl[k], es); end
    end
  endtask

  task automatic test_lw_wait();
    step_t q[$]; obs_t obs[$]; logic [3:0] es;
    build(OP_LW, 6'h15, 1'b0, 0, 2, q);
    run_trace(OP_LW, 6'h15, 1'b0, q, obs, es);
    for (int i = 0; i < q.size(); i++) begin
      checks++;
      if (obs[i] !== q[i].o) begin
        errs++; $display("FAIL lw_wait cyc%0d: got %05h want %05h", i, obs[i], q[i].o);
      end
    end
    checks++;
    if (es !== 4'd0) begin errs++; $display("FAIL lw_wait_end: got %0d want 0", es); end
  endtask

  task automatic test_beq();
    step_t q[$]; obs_t obs[$]; logic [3:0] es;
    for (int zi = 1; zi >= 0; zi--) begin
      build(OP_BEQ, 6'h2a, 1'(zi), 0, 0, q);
      run_trace(OP_BEQ, 6'h2a, 1'(zi), q, obs, es);
      for (int i = 0; i < q.size(); i++) begin
        checks++;
        if (obs[i] !== q[i].o) begin
          errs++; $display("FAIL beq z=%0d cyc%0d: got %05h want %05h", zi, i, obs[i], q[i].o);
        end
      end
      checks++;
      if (es !== 4'd0) begin errs++; $display("FAIL beq_end z=%0d: got %0d want 0", zi, es); end
    end
  endtask

  task automatic test_sw_j();
    logic [5:0] ops [0:1];
    step_t q[$]; obs_t obs[$]; logic [3:0] es;
    ops = '{OP_SW, OP_J};
    foreach (ops[k]) begin
      build(ops[k], 6'h00, 1'b1, 1, 1, q);
      run_trace(ops[k], 6'h00, 1'b1, q, obs, es);
      for (int i = 0; i < q.size(); i++) begin
        checks++;
        if (obs[i] !== q[i].o) begin
          errs++; $display("FAIL sw_j op=%b cyc%0d: got %05h want %05h", ops[k], i, obs[i], q[i].o);
        end
      end
      checks++;
      if (es !== 4'd0) begin errs++; $display("FAIL sw_j_end op=%b: got %0d want 0", ops[k], es); end
    end
  endtask

  task automatic test_illegal();
    logic [5:0] ops [0:1];
    step_t q[$]; obs_t obs[$]; logic [3:0] es;
    ops = '{6'b111111, OP_R};
    foreach (ops[k]) begin
      build(ops[k], 6'b000000, 1'b1, 0, 0, q);
      run_trace(ops[k], 6'b000000, 1'b1, q, obs, es);
      for (int i = 0; i < q.size(); i++) begin
        checks++;
        if (obs[i] !== q[i].o) begin
          errs++; $display("FAIL illegal op=%b cyc%0d: got %05h want %05h", ops[k], i, obs[i], q[i].o);
        end
      end
      checks++;
      if (es !== 4'd0) begin errs++; $display("FAIL illegal_end op=%b: got %0d want 0", ops[k], es); end
    end
  endtask

  task automatic test_reset_mid();
    obs_t o, exp_f;
    bus.opcode = OP_ADDI; bus.funct = 6'h11; bus.memReady = 1'b1; bus.zero = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (bus.state !== 4'd9) begin errs++; $display("FAIL mid_reset_pre: got %0d want 9", bus.state); end
    reset = 1'b1;
    #3;
    o = sample();
    exp_f = '0; exp_f.aop = 3'b010; exp_f.st = 4'd9;
    checks++;
    if (o !== exp_f) begin errs++; $display("FAIL mid_reset_forced: got %05h want %05h", o, exp_f); end
    @(posedge clk);
    #1;
    checks++;
    if (bus.state !== 4'd0 || bus.regWrite !== 1'b0) begin
      errs++; $display("FAIL mid_reset_after: got st=%0d rw=%0b want st=0 rw=0", bus.state, bus.regWrite);
    end
    reset = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [5:0] legal [0:5];
    logic [5:0] bad [0:3];
    logic [5:0] op, fn;
    logic z;
    int fw, mw;
    step_t q[$]; obs_t obs[$]; logic [3:0] es;
    legal = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
    bad   = '{6'b111111, 6'b000001, 6'b100000, 6'b001100};
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 6) == 0) op = bad[$urandom_range(0, 3)];
      else                           op = legal[$urandom_range(0, 5)];
      case ($urandom_range(0, 5))
        0: fn = 6'b100000;
        1: fn = 6'b100010;
        2: fn = 6'b100100;
        3: fn = 6'b100101;
        4: fn = 6'b101010;
        default: fn = 6'($urandom_range(0, 63));
      endcase
      z  = 1'($urandom_range(0, 1));
      fw = $urandom_range(0, 2);
      mw = $urandom_range(0, 3);
      build(op, fn, z, fw, mw, q);
      run_trace(op, fn, z, q, obs, es);
      for (int i = 0; i < q.size(); i++) begin
        checks++;
        if (obs[i] !== q[i].o) begin
          errs++;
          $display("FAIL b2b n=%0d op=%b f=%b cyc%0d: got %05h want %05h", n, op, fn, i, obs[i], q[i].o);
        end
      end
      checks++;
      if (es !== 4'd0) begin errs++; $display("FAIL b2b_end n=%0d: got %0d want 0", n, es); end
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.opcode = 6'b0; bus.funct = 6'b0; bus.zero = 1'b0; bus.memReady = 1'b0;
    test_reset();
    test_rtype();
    test_lw_wait();
    test_beq();
    test_sw_j();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
